// File: rtl/burst_ram_pkg.sv
// -----------------------------------------------------------------------------
// burst_ram_pkg
//   Shared definitions for the burst_ram block: one-hot controller state
//   encodings, burst length and data/mask widths, plus the byte-enable helper.
//
//   Configuration macro: BURST_RAM_DATA_MASK_EN
//     defined   -> data_mask bits set to 1 suppress the write of that byte
//     undefined -> data_mask is ignored, every beat writes all 8 bytes
// -----------------------------------------------------------------------------
package burst_ram_pkg;

    localparam int unsigned DATA_WIDTH  = 64;
    localparam int unsigned MASK_WIDTH  = 8;
    localparam int unsigned BURST_COUNT = 4;
    localparam int unsigned BEAT_BITS   = 2;

`ifdef BURST_RAM_DATA_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    typedef enum logic [7:0] {
        INIT        = 8'b0000_0001,
        IDLE        = 8'b0000_0010,
        READ_WAIT   = 8'b0000_0100,
        READ_BURST  = 8'b0000_1000,
        WRITE_BURST = 8'b0001_0000
    } state_t;

    // data_mask is "1 = do not write"; storage wants "1 = write".
    function automatic logic [MASK_WIDTH-1:0] byte_enables(input logic [MASK_WIDTH-1:0] mask);
        return MASK_EN ? ~mask : '1;
    endfunction

endpackage

// File: rtl/burst_ram_storage.sv
// -----------------------------------------------------------------------------
// burst_ram_storage
//   Single-port synchronous RAM, 64-bit words, per-byte write enables,
//   depth 2**DEPTH_BITWIDTH. Read data appears the cycle after the address.
//   Contents start at zero.
//
//   Ports:
//     clk      in   clock, rising edge
//     we       in   write enable for this cycle
//     addr     in   word address (read and write)
//     wr_data  in   write word
//     byte_en  in   per-byte write enable (1 = write byte)
//     rd_data  out  registered read word
// -----------------------------------------------------------------------------
module burst_ram_storage
    import burst_ram_pkg::*;
#(
    parameter int unsigned DEPTH_BITWIDTH = 4,
    parameter string       DATA_FILE      = ""
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [DEPTH_BITWIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [MASK_WIDTH-1:0]     byte_en,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITWIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage initialiser; reset never touches the array.
    initial begin
        mem = '{default: '0};
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < MASK_WIDTH; b++) begin
                if (byte_en[b]) begin
                    mem[addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        rd_data <= mem[addr];
    end

endmodule

// File: rtl/burst_ram.sv
// -----------------------------------------------------------------------------
// burst_ram
//   Burst memory model: 4-beat x 64-bit bursts (one 32-byte line) with a
//   programmable read latency and a post-reset initialisation delay.
//   Holds only the controller, counters and beat address; storage lives in
//   burst_ram_storage.
//
//   Configuration macro: BURST_RAM_DATA_MASK_EN (byte masking on writes).
//
//   Ports:
//     clk            in   clock, rising edge
//     rst            in   synchronous, active-high reset
//     cmd            in   0 = read, 1 = write
//     cmd_en         in   cmd/addr valid (accepted only when idle)
//     addr           in   burst start word address
//     wr_data        in   write beat data (beat 0 on the command cycle)
//     data_mask      in   per-byte mask, 1 = byte not written
//     rd_data        out  read beat data, holds when rd_data_ready = 0
//     rd_data_ready  out  rd_data valid this cycle
//     busy           out  commands ignored while high
//     init_done      out  init delay elapsed
// -----------------------------------------------------------------------------
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int unsigned DEPTH_BITWIDTH           = 4,
    parameter string       DATA_FILE                = "",
    parameter int unsigned CYCLES_BEFORE_DATA_VALID = 6,
    parameter int unsigned CYCLES_BEFORE_INITIATED  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd,
    input  logic                      cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [MASK_WIDTH-1:0]     data_mask,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_data_ready,
    output logic                      busy,
    output logic                      init_done
);

    // READ_WAIT lasts L-1 cycles; the counter is preloaded with L-2 and the
    // state is skipped entirely when L = 1.
    localparam bit          LAT_ONE     = (CYCLES_BEFORE_DATA_VALID <= 1);
    localparam logic [7:0]  LAT_PRELOAD = LAT_ONE ? 8'd0 : 8'(CYCLES_BEFORE_DATA_VALID - 2);
    localparam bit          INIT_SKIP   = (CYCLES_BEFORE_INITIATED == 0);
    localparam logic [15:0] INIT_LAST   = INIT_SKIP ? 16'd0 : 16'(CYCLES_BEFORE_INITIATED - 1);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BURST_COUNT - 1);

    state_t state;
    state_t state_next;

    logic [7:0]                lat_cnt;
    logic [15:0]               init_cnt;
    logic [BEAT_BITS-1:0]      beat_cnt;
    logic [DEPTH_BITWIDTH-1:0] beat_addr;
    logic [DATA_WIDTH-1:0]     rd_hold;

    logic                      ram_we;
    logic [DEPTH_BITWIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_q;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        state <= state_next;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        case (state)
            INIT:        if (init_cnt == INIT_LAST) state_next = IDLE;
            IDLE:        if (cmd_en) begin
                             if (cmd)          state_next = WRITE_BURST;
                             else if (LAT_ONE) state_next = READ_BURST;
                             else              state_next = READ_WAIT;
                         end
            READ_WAIT:   if (lat_cnt == 8'd0) state_next = READ_BURST;
            READ_BURST:  if (beat_cnt == LAST_BEAT) state_next = IDLE;
            WRITE_BURST: if (beat_cnt == LAST_BEAT) state_next = IDLE;
            default:     state_next = INIT;
        endcase
        // A zero init delay lands in IDLE directly from reset; outputs stay
        // forced to their reset values while rst is held.
        if (rst) begin
            state_next = INIT_SKIP ? IDLE : INIT;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy          = 1'b1;
        init_done     = 1'b0;
        rd_data_ready = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = beat_addr;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                init_done = 1'b1;
                // The command cycle addresses the RAM directly so write beat 0
                // lands immediately and a 1-cycle read latency is reachable.
                ram_addr  = addr;
                ram_we    = cmd_en & cmd;
            end
            READ_WAIT: begin
                init_done = 1'b1;
            end
            READ_BURST: begin
                init_done     = 1'b1;
                rd_data_ready = 1'b1;
            end
            WRITE_BURST: begin
                init_done = 1'b1;
                ram_we    = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
        if (rst) begin
            busy          = 1'b1;
            init_done     = 1'b0;
            rd_data_ready = 1'b0;
            ram_we        = 1'b0;
        end
    end

    // -------------------------------------------------- counters / address
    // beat_addr always holds the address the RAM needs on the next edge:
    // the word after the one being transferred during a burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt  <= '0;
            lat_cnt   <= '0;
            beat_cnt  <= '0;
            beat_addr <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 16'd1;
                end
                IDLE: begin
                    if (cmd_en) begin
                        lat_cnt   <= LAT_PRELOAD;
                        beat_cnt  <= cmd ? BEAT_BITS'(1) : '0;
                        beat_addr <= (cmd || LAT_ONE) ? addr + 1'b1 : addr;
                    end
                end
                READ_WAIT: begin
                    if (lat_cnt == 8'd0) begin
                        beat_cnt  <= '0;
                        beat_addr <= beat_addr + 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                READ_BURST, WRITE_BURST: begin
                    beat_cnt  <= beat_cnt + 1'b1;
                    beat_addr <= beat_addr + 1'b1;
                end
                default: begin
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------- read data hold
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_hold <= '0;
        end else if (rd_data_ready) begin
            rd_hold <= ram_q;
        end
    end

    assign rd_data = rst           ? '0    :
                     rd_data_ready ? ram_q : rd_hold;

    // -------------------------------------------------------------- storage
    burst_ram_storage #(
        .DEPTH_BITWIDTH (DEPTH_BITWIDTH),
        .DATA_FILE      (DATA_FILE)
    ) u_storage (
        .clk     (clk),
        .we      (ram_we),
        .addr    (ram_addr),
        .wr_data (wr_data),
        .byte_en (byte_enables(data_mask)),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_burst_ram.sv
// -----------------------------------------------------------------------------
// tb_burst_ram
//   Self-checking bench for burst_ram (DEPTH_BITWIDTH=4, L=6, init=10).
//   A word-level memory model supplies expected read data; expected beats are
//   queued when a read is issued and compared when rd_data_ready is seen.
// -----------------------------------------------------------------------------
module tb_burst_ram;

    localparam int unsigned DB = 4;
    localparam int unsigned L  = 6;
    localparam int unsigned N  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd = 1'b0;
    logic        cmd_en = 1'b0;
    logic [3:0]  addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  data_mask = '0;
    logic [63:0] rd_data;
    logic        rd_data_ready;
    logic        busy;
    logic        init_done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [63:0] model [16] = '{default: '0};
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    burst_ram #(
        .DEPTH_BITWIDTH           (DB),
        .DATA_FILE                (""),
        .CYCLES_BEFORE_DATA_VALID (L),
        .CYCLES_BEFORE_INITIATED  (N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd           (cmd),
        .cmd_en        (cmd_en),
        .addr          (addr),
        .wr_data       (wr_data),
        .data_mask     (data_mask),
        .rd_data       (rd_data),
        .rd_data_ready (rd_data_ready),
        .busy          (busy),
        .init_done     (init_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = new_w;
`ifdef BURST_RAM_DATA_MASK_EN
        for (int unsigned b = 0; b < 8; b++) begin
            if (m[b]) r[b*8 +: 8] = old_w[b*8 +: 8];
        end
`else
        if (m == 8'hA5) r = new_w | old_w; // unreachable mask in this bench
`endif
        return r;
    endfunction

    // Scoreboard: every read beat must match the queued expectation.
    always @(negedge clk) begin
        if (rd_data_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 64'(rd_data_ready), 64'd0);
            end else begin
                check_eq("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    // Tasks start just after a rising edge (start of a cycle) and return at
    // the start of the cycle following their last checked cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int unsigned hold);
        rst = 1'b1;
        cmd_en = 1'b0;
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("rst_busy",      64'(busy),          64'd1);
            check_eq("rst_init_done", 64'(init_done),     64'd0);
            check_eq("rst_ready",     64'(rd_data_ready), 64'd0);
            check_eq("rst_rd_data",   rd_data,            64'd0);
            next_cycle();
        end
        // A write command held through init must be ignored.
        rst = 1'b0;
        cmd_en = 1'b1;
        cmd = 1'b1;
        addr = 4'd0;
        wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        data_mask = '0;
        for (int unsigned j = 1; j <= N; j++) begin
            @(negedge clk);
            check_eq("init_busy",      64'(busy),          64'd1);
            check_eq("init_init_done", 64'(init_done),     64'd0);
            check_eq("init_ready",     64'(rd_data_ready), 64'd0);
            next_cycle();
        end
        cmd_en = 1'b0;
        @(negedge clk);
        check_eq("post_init_busy",      64'(busy),      64'd0);
        check_eq("post_init_init_done", 64'(init_done), 64'd1);
        next_cycle();
    endtask

    task automatic do_read(input logic [3:0] a);
        logic [3:0] wa;
        cmd_en = 1'b1;
        cmd = 1'b0;
        addr = a;
        for (int unsigned k = 0; k < 4; k++) begin
            wa = a + 4'(k);
            exp_q.push_back(model[wa]);
        end
        @(negedge clk);
        check_eq("rd_cmd_busy", 64'(busy), 64'd0);
        for (int unsigned i = 1; i <= L + 3; i++) begin
            next_cycle();
            cmd_en = 1'b0;
            @(negedge clk);
            check_eq("rd_busy",  64'(busy),          64'd1);
            check_eq("rd_ready", 64'(rd_data_ready), 64'(i >= L));
        end
        next_cycle();
    endtask

    // abort_at < 4: return at the start of that beat's cycle without driving
    // it; the caller asserts reset there.
    task automatic do_write(input logic [3:0] a,
                            input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3,
                            input logic [7:0] m0, input int unsigned abort_at);
        logic [3:0]  wa;
        logic [63:0] beat;
        for (int unsigned k = 0; k < 4; k++) begin
            if (k == abort_at) break;
            beat = (k == 0) ? d0 : (k == 1) ? d1 : (k == 2) ? d2 : d3;
            cmd_en = (k == 0);
            cmd = 1'b1;
            addr = a;
            wr_data = beat;
            data_mask = (k == 0) ? m0 : 8'h00;
            wa = a + 4'(k);
            model[wa] = merge(model[wa], beat, data_mask);
            @(negedge clk);
            check_eq("wr_busy",  64'(busy),          (k == 0) ? 64'd0 : 64'd1);
            check_eq("wr_ready", 64'(rd_data_ready), 64'd0);
            next_cycle();
        end
        data_mask = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        next_cycle();
        apply_reset(3);

        do_read(4'd0);

        do_write(4'd4, 64'h04, 64'h05, 64'h06, 64'h07, 8'h00, 4);
        do_read(4'd4);

        do_write(4'd8, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 8'h00, 4);
        do_read(4'd8);

        do_write(4'd14, 64'h0E, 64'h0F, 64'h100, 64'h101, 8'h00, 4);
        do_read(4'd14);
        do_read(4'd0);

        do_write(4'd0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111,
                 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 8'h00, 4);
        do_write(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 8'h0F, 4);
        check_eq("mask_model_word0", model[0],
`ifdef BURST_RAM_DATA_MASK_EN
                 64'hFFFF_FFFF_1111_1111);
`else
                 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        do_read(4'd0);

        // Write aborted by reset on its third beat: beats 0,1 stay written.
        do_write(4'd8, 64'hB0, 64'hB1, 64'hB2, 64'hB3, 8'h00, 2);
        apply_reset(1);
        do_read(4'd8);

        // Read interrupted by reset at T+L+1: only beat 0 is delivered.
        cmd_en = 1'b1;
        cmd = 1'b0;
        addr = 4'd4;
        exp_q.push_back(model[4]);
        @(negedge clk);
        check_eq("abort_rd_cmd_busy", 64'(busy), 64'd0);
        for (int unsigned i = 1; i <= L; i++) begin
            next_cycle();
            cmd_en = 1'b0;
            @(negedge clk);
            check_eq("abort_rd_ready", 64'(rd_data_ready), 64'(i >= L));
        end
        next_cycle();
        apply_reset(1);
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

        do_read(4'd4);
        do_read(4'd8);

        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("final_idle_busy",  64'(busy),          64'd0);
            check_eq("final_idle_ready", 64'(rd_data_ready), 64'd0);
            next_cycle();
        end
        check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 The module SHALL have parameter DEPTH_BITWIDTH, default 4, meaning log2 of the number of 64-bit words.
REQ-002 The module SHALL have parameter DATA_FILE, default "", meaning a hex file loaded into storage at elaboration; empty means all zeros.
REQ-003 The module SHALL have parameter CYCLES_BEFORE_DATA_VALID, default 6, legal range 1..255, meaning read latency in cycles.
REQ-004 The module SHALL have parameter CYCLES_BEFORE_INITIATED, default 10, legal range 0..65535, meaning the post-reset init delay.
REQ-005 The module SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have port cmd, input, 1 bit: 0 = read, 1 = write.
REQ-008 The module SHALL have port cmd_en, input, 1 bit: cmd and addr valid this cycle.
REQ-009 The module SHALL have port addr, input, DEPTH_BITWIDTH bits: start word address.
REQ-010 The module SHALL have port wr_data, input, 64 bits: write beat data.
REQ-011 The module SHALL have port data_mask, input, 8 bits: per-byte mask, where 1 means the byte is not written.
REQ-012 The module SHALL have port rd_data, output, 64 bits: read beat data.
REQ-013 The module SHALL have port rd_data_ready, output, 1 bit: rd_data valid this cycle.
REQ-014 The module SHALL have port busy, output, 1 bit: commands ignored while high.
REQ-015 The module SHALL have port init_done, output, 1 bit: init delay elapsed.

Function
REQ-016 The block SHALL implement the states INIT, IDLE, READ_WAIT, READ_BURST and WRITE_BURST, with a burst length of 4 beats of 64 bits (one 32-byte cache line).
REQ-017 In INIT, busy SHALL be 1 and init_done 0 for CYCLES_BEFORE_INITIATED cycles after rst deasserts, then the block SHALL enter IDLE with busy=0 and init_done=1; a value of 0 enters IDLE on the first cycle after reset.
REQ-018 A command SHALL be accepted only in IDLE with cmd_en=1; cmd_en at any other time SHALL be ignored with no side effect.
REQ-019 For a read accepted at cycle T, busy SHALL be 1 from T+1 to T+L+3, where L = CYCLES_BEFORE_DATA_VALID.
REQ-020 For that read, rd_data_ready SHALL be 1 exactly on cycles T+L..T+L+3, with rd_data equal to words addr, addr+1, addr+2, addr+3.
REQ-021 For that read, busy SHALL be 0 at T+L+4, and a new command SHALL be acceptable in that cycle.
REQ-022 For a write accepted at cycle T, wr_data and data_mask sampled at T..T+3 SHALL be written to words addr..addr+3 (beat 0 is the command cycle).
REQ-023 For that write, busy SHALL be 1 from T+1 to T+3 and 0 at T+4; rd_data_ready SHALL stay 0.
REQ-024 Word addresses SHALL increment modulo 2^DEPTH_BITWIDTH, so a burst wraps from the last word to word 0.
REQ-025 A read accepted one cycle after a write burst completes SHALL return the newly written data.
REQ-026 rd_data SHALL hold its last value when rd_data_ready=0.
REQ-027 The latency counter SHALL be 8 bits and the init counter 16 bits, with no overflow inside the legal parameter ranges.

Reset
REQ-028 When rst=1 the block SHALL enter INIT, aborting any burst in progress.
REQ-029 During rst=1, outputs SHALL be rd_data_ready=0, busy=1, init_done=0 and rd_data=0.
REQ-030 Storage contents SHALL NOT be cleared by reset.
REQ-031 Beats of an aborted write already written SHALL remain written; the remaining beats SHALL NOT be written.
REQ-032 The init delay SHALL restart on every reset.

Configuration
REQ-033 With macro BURST_RAM_DATA_MASK_EN defined, each write beat SHALL update only the bytes whose data_mask bit is 0.
REQ-034 Without BURST_RAM_DATA_MASK_EN, data_mask SHALL be ignored and every write beat SHALL write all 8 bytes.

Structure
REQ-035 A shared package SHALL hold the state encodings (one-hot, 8 bits), BURST_COUNT=4, and the widths 64 for data and 8 for mask.
REQ-036 One sub-module, burst_ram_storage, SHALL be used: a single-port 64-bit byte-enable synchronous RAM of depth 2^DEPTH_BITWIDTH with a DATA_FILE initialiser.
REQ-037 burst_ram SHALL contain only control logic, counters and the beat address register.

Verification
REQ-038 Init: deassert rst, CYCLES_BEFORE_INITIATED=10 -> busy=1 for 10 cycles, then busy=0 and init_done=1; cmd_en during init is ignored.
REQ-039 Read: DATA_FILE words 4..7 = 0x04..0x07, read addr=4 at T, L=6 -> rd_data_ready high T+6..T+9 with data 0x04, 0x05, 0x06, 0x07; busy=0 at T+10.
REQ-040 Write then read: write addr=8 with beats 0xA0..0xA3, then read addr=8 at T+4 -> returns 0xA0, 0xA1, 0xA2, 0xA3.
REQ-041 Wrap: DEPTH_BITWIDTH=4, read addr=14 -> data from words 14, 15, 0, 1.
REQ-042 Mask: word 0 = 0x1111111111111111, write beat 0xFFFFFFFFFFFFFFFF with mask 0x0F -> with BURST_RAM_DATA_MASK_EN readback is 0xFFFFFFFF11111111; without it, 0xFFFFFFFFFFFFFFFF.
REQ-043 Reset mid-read: assert rst at T+7 of a read -> rd_data_ready=0 from the next cycle, the INIT delay reruns, storage is unchanged.
